// File: rtl/ps2_host_ctrl.sv
// PS/2 host-side command controller: inhibit, request-to-send, 11-bit frame, line ACK, response/retry/timeout,
// plus filtering of command responses from the receive stream. Define PS2_LED_CMD_EN to add the LED sequencer.
module ps2_host_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned FILT           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       done,
  output logic       error,
  input  logic [7:0] rx_code,
  input  logic       rx_strobe,
  output logic [7:0] fwd_code,
  output logic       fwd_strobe,
  input  logic [2:0] leds
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned FW      = (FILT < 2) ? 1 : $clog2(FILT);
  localparam int unsigned RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_TX,
    S_LINE_ACK,
    S_WAIT_RESP
  } state_t;

  state_t state, state_nx;

  logic          clk_s1, clk_s2, clk_filt, clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          data_s1, data_s2;
  logic          fall;

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    tx_byte;
  logic          parity;

  logic       load_cmd, start_tx, tx_bit, enter_ack, enter_wait;
  logic       resend, do_retry, do_fail, do_done, timer_exp, retry_ok;
  logic [7:0] load_byte;
  logic       resp_hit;

  logic       led_busy, led_req, led_take;
  logic [7:0] led_byte;

  // Clock input: 2-flop sync, then a level is accepted only after FILT consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
      data_s1    <= 1'b1;
      data_s2    <= 1'b1;
    end else begin
      clk_s1     <= ps2_clk_in;
      clk_s2     <= clk_s1;
      data_s1    <= ps2_data_in;
      data_s2    <= data_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall      = clk_filt_d & ~clk_filt;
  assign timer_exp = (cnt == CW'(1));
  assign retry_ok  = (retry_cnt < RW'(MAX_RETRY));

  assign ps2_clk_oe = (state == S_INHIBIT);
  assign cmd_ready  = (state == S_IDLE) && !led_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_cmd   = 1'b0;
    load_byte  = cmd_byte;
    led_take   = 1'b0;
    start_tx   = 1'b0;
    tx_bit     = 1'b0;
    enter_ack  = 1'b0;
    enter_wait = 1'b0;
    resend     = 1'b0;
    do_retry   = 1'b0;
    do_fail    = 1'b0;
    do_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load_cmd = 1'b1;
          state_nx = S_INHIBIT;
        end else if (led_req) begin
          load_cmd  = 1'b1;
          load_byte = led_byte;
          led_take  = 1'b1;
          state_nx  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt <= CW'(1)) begin
          start_tx = 1'b1;
          state_nx = S_TX;
        end
      end
      S_TX: begin
        if (fall) begin
          if (bit_idx == 4'd9) begin
            enter_ack = 1'b1;
            state_nx  = S_LINE_ACK;
          end else begin
            tx_bit = 1'b1;
          end
        end else if (timer_exp) begin
          do_fail  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_LINE_ACK: begin
        if (fall) begin
          if (!data_s2) begin
            enter_wait = 1'b1;
            state_nx   = S_WAIT_RESP;
          end else begin
            resend = 1'b1;
          end
        end else if (timer_exp) begin
          do_fail  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WAIT_RESP: begin
        if (rx_strobe && rx_code == RESP_ACK) begin
          do_done  = 1'b1;
          state_nx = S_IDLE;
        end else if (rx_strobe && rx_code == RESP_RESEND) begin
          resend = 1'b1;
        end else if (timer_exp) begin
          do_fail  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (resend) begin
      if (retry_ok) begin
        do_retry = 1'b1;
        state_nx = S_INHIBIT;
      end else begin
        do_fail  = 1'b1;
        state_nx = S_IDLE;
      end
    end
  end

  // One counter serves both the inhibit interval and the device-wait timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      retry_cnt   <= '0;
      tx_byte     <= '0;
      parity      <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= do_done;
      error <= do_fail;
      if (load_cmd) begin
        tx_byte   <= load_byte;
        parity    <= ~^load_byte;
        retry_cnt <= '0;
        cnt       <= CW'(INHIBIT_CYCLES);
      end else if (do_retry) begin
        retry_cnt <= retry_cnt + RW'(1);
        cnt       <= CW'(INHIBIT_CYCLES);
      end else if (start_tx || tx_bit || enter_ack || enter_wait) begin
        cnt <= CW'(TIMEOUT_CYCLES);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (start_tx)      bit_idx <= '0;
      else if (tx_bit)   bit_idx <= bit_idx + 4'd1;
      if (start_tx)
        ps2_data_oe <= 1'b1;
      else if (tx_bit)
        ps2_data_oe <= (bit_idx == 4'd8) ? ~parity : ~tx_byte[bit_idx[2:0]];
      else if (state_nx != S_TX)
        ps2_data_oe <= 1'b0;
    end
  end

  assign resp_hit = (state == S_WAIT_RESP) && (rx_code == RESP_ACK || rx_code == RESP_RESEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_strobe <= 1'b0;
      fwd_code   <= '0;
    end else begin
      fwd_strobe <= rx_strobe && !resp_hit;
      if (rx_strobe && !resp_hit) fwd_code <= rx_code;
    end
  end

`ifdef PS2_LED_CMD_EN
  typedef enum logic [1:0] {
    L_NONE,
    L_ED,
    L_DUE,
    L_VAL
  } led_phase_t;

  led_phase_t led_phase;
  logic [2:0] led_q, led_prev;
  logic       led_pend;

  assign led_busy = (led_phase != L_NONE);
  assign led_req  = (led_phase == L_DUE) || ((led_phase == L_NONE) && led_pend);
  assign led_byte = (led_phase == L_DUE) ? {5'b0, led_q} : 8'hED;

  // L_DUE: 0xED was acknowledged and the LED value byte goes out on the next idle cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      led_prev  <= '0;
      led_pend  <= 1'b0;
      led_phase <= L_NONE;
    end else begin
      led_q    <= leds;
      led_prev <= led_q;
      if (led_q != led_prev)
        led_pend <= 1'b1;
      else if (led_take && led_phase == L_NONE)
        led_pend <= 1'b0;
      if (do_fail)
        led_phase <= L_NONE;
      else if (do_done)
        led_phase <= (led_phase == L_ED) ? L_DUE : L_NONE;
      else if (led_take)
        led_phase <= (led_phase == L_DUE) ? L_VAL : L_ED;
    end
  end
`else
  logic unused_led;

  assign led_busy   = 1'b0;
  assign led_req    = 1'b0;
  assign led_byte   = '0;
  assign unused_led = ^{leds, led_take};
`endif

endmodule
